vga_timing_gen: RTL and testbench

//  Parametrised VGA raster timing generator; successor to the fixed 640x480 controller.

---
 rtl/vga_timing_gen_if.sv | 36 +++
 rtl/vga_timing_gen.sv | 128 ++++++++++++
 tb/tb_vga_timing_gen.sv | 135 +++++++++++++
 3 files changed

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bundle between the VGA timing generator and its consumers
interface vga_timing_gen_if #(
    parameter int CNT_W = 11
);
    logic             en;
    logic             pix_ce;
    logic             pixel_clk;
    logic             hs;
    logic             vs;
    logic             blank;
    logic             sync;
    logic [CNT_W-1:0] DrawX;
    logic [CNT_W-1:0] DrawY;
    logic             line_start;
    logic             frame_start;
`ifdef VGA_LOOKAHEAD_EN
    logic [CNT_W-1:0] NextX;
    logic [CNT_W-1:0] NextY;
`endif

    modport master (
        input  en,
        output pix_ce, pixel_clk, hs, vs, blank, sync, DrawX, DrawY, line_start, frame_start
`ifdef VGA_LOOKAHEAD_EN
        , output NextX, NextY
`endif
    );

    modport slave (
        output en,
        input  pix_ce, pixel_clk, hs, vs, blank, sync, DrawX, DrawY, line_start, frame_start
`ifdef VGA_LOOKAHEAD_EN
        , input NextX, NextY
`endif
    );
endinterface

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised VGA raster timing generator (VGA_LOOKAHEAD_EN adds NextX/NextY)
module vga_timing_gen #(
    parameter int CNT_W    = 11,
    parameter int CLK_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0
) (
    input logic                Clk,
    input logic                Reset_n,
    vga_timing_gen_if.master   vif
);
    localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HS_START = H_ACTIVE + H_FP;
    localparam int HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int VS_START = V_ACTIVE + V_FP;
    localparam int VS_END   = V_ACTIVE + V_FP + V_SYNC;
    localparam int DIV_W    = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOTAL - 1);

    logic [DIV_W-1:0] r_div_cnt;
    logic [CNT_W-1:0] r_x, r_y;
    logic             r_hs, r_vs, r_blank;
    logic             r_line_start, r_frame_start;
    logic             w_pix_ce;
    logic [CNT_W-1:0] w_next_x, w_next_y;
    logic             w_next_hs, w_next_vs, w_next_blank;

    // Raster successor of (x, y), wrapping both axes.
    function automatic logic [2*CNT_W-1:0] advance(input logic [CNT_W-1:0] x,
                                                   input logic [CNT_W-1:0] y);
        logic [CNT_W-1:0] nx;
        logic [CNT_W-1:0] ny;
        nx = x + CNT_W'(1);
        ny = y;
        if (x == H_LAST) begin
            nx = '0;
            ny = (y == V_LAST) ? '0 : y + CNT_W'(1);
        end
        return {nx, ny};
    endfunction

    // Extra bit keeps thresholds equal to 2**CNT_W representable.
    function automatic logic below(input logic [CNT_W-1:0] v, input int lim);
        return {1'b0, v} < (CNT_W+1)'(lim);
    endfunction

    assign w_pix_ce               = vif.en & (r_div_cnt == DIV_LAST);
    assign {w_next_x, w_next_y}   = advance(r_x, r_y);
    assign w_next_hs    = (!below(w_next_x, HS_START) && below(w_next_x, HS_END)) ? HS_POL : ~HS_POL;
    assign w_next_vs    = (!below(w_next_y, VS_START) && below(w_next_y, VS_END)) ? VS_POL : ~VS_POL;
    assign w_next_blank = below(w_next_x, H_ACTIVE) && below(w_next_y, V_ACTIVE);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_div_cnt <= '0;
        end else if (vif.en) begin
            r_div_cnt <= (r_div_cnt == DIV_LAST) ? '0 : r_div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x           <= '0;
            r_y           <= '0;
            r_hs          <= ~HS_POL;
            r_vs          <= ~VS_POL;
            r_blank       <= 1'b1;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_line_start  <= w_pix_ce && (w_next_x == '0);
            r_frame_start <= w_pix_ce && (w_next_x == '0) && (w_next_y == '0);
            // Sync/blank load from the next counter values so they never lag DrawX/DrawY.
            if (w_pix_ce) begin
                r_x     <= w_next_x;
                r_y     <= w_next_y;
                r_hs    <= w_next_hs;
                r_vs    <= w_next_vs;
                r_blank <= w_next_blank;
            end
        end
    end

    generate
        if (CLK_DIV == 1) begin : g_pclk_const
            assign vif.pixel_clk = 1'b1;
        end else begin : g_pclk_div
            assign vif.pixel_clk = (r_div_cnt >= DIV_W'(CLK_DIV / 2));
        end
    endgenerate

    assign vif.pix_ce      = w_pix_ce;
    assign vif.hs          = r_hs;
    assign vif.vs          = r_vs;
    assign vif.blank       = r_blank;
    assign vif.sync        = 1'b0;
    assign vif.DrawX       = r_x;
    assign vif.DrawY       = r_y;
    assign vif.line_start  = r_line_start & vif.en;
    assign vif.frame_start = r_frame_start & vif.en;

`ifdef VGA_LOOKAHEAD_EN
    logic [CNT_W-1:0] r_nx, r_ny;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            {r_nx, r_ny} <= advance('0, '0);
        end else if (w_pix_ce) begin
            {r_nx, r_ny} <= advance(w_next_x, w_next_y);
        end
    end

    assign vif.NextX = r_nx;
    assign vif.NextY = r_ny;
`endif
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - scoreboard bench for vga_timing_gen on a small raster geometry
module tb_vga_timing_gen;
    localparam int CNT_W   = 6;
    localparam int CLK_DIV = 3;
    localparam int HA = 8, HF = 2, H_SY = 3, HB = 2;
    localparam int VA = 4, VF = 1, V_SY = 2, VB = 2;
    localparam int HT = HA + HF + H_SY + HB;
    localparam int VT = VA + VF + V_SY + VB;
    localparam bit HS_POL = 1'b1;
    localparam bit VS_POL = 1'b0;

    typedef struct {
        bit pce, pclk, hs, vs, blank, ls, fs;
        int x, y;
    } exp_t;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   e_cnt = 0;
    bit   prev_pce = 1'b0;

    vga_timing_gen_if #(.CNT_W(CNT_W)) vif();

    vga_timing_gen #(
        .CNT_W(CNT_W), .CLK_DIV(CLK_DIV),
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(H_SY), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(V_SY), .V_BP(VB),
        .HS_POL(HS_POL), .VS_POL(VS_POL)
    ) dut (
        .Clk(Clk),
        .Reset_n(Reset_n),
        .vif(vif)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected raster position follows purely from the number of enabled clocks since reset.
    task automatic step(input bit en_v, input bit rst_v);
        exp_t e;
        int   ph, n;
        @(posedge Clk);
        #1;
        Reset_n = rst_v;
        vif.en  = en_v;
        if (!rst_v) begin
            e_cnt    = 0;
            prev_pce = 1'b0;
        end
        ph      = e_cnt % CLK_DIV;
        n       = e_cnt / CLK_DIV;
        e.x     = n % HT;
        e.y     = (n / HT) % VT;
        e.pce   = en_v && rst_v && (ph == CLK_DIV - 1);
        e.pclk  = (ph >= CLK_DIV / 2);
        e.hs    = (e.x >= HA + HF && e.x < HA + HF + H_SY) ? HS_POL : !HS_POL;
        e.vs    = (e.y >= VA + VF && e.y < VA + VF + V_SY) ? VS_POL : !VS_POL;
        e.blank = (e.x < HA) && (e.y < VA);
        e.ls    = en_v && prev_pce && (e.x == 0);
        e.fs    = e.ls && (e.y == 0);
        exp_q.push_back(e);
        if (rst_v) begin
            prev_pce = e.pce;
            if (en_v) e_cnt++;
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge Clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pix_ce",      int'(vif.pix_ce),      int'(e.pce));
                chk("pixel_clk",   int'(vif.pixel_clk),   int'(e.pclk));
                chk("DrawX",       int'(vif.DrawX),       e.x);
                chk("DrawY",       int'(vif.DrawY),       e.y);
                chk("hs",          int'(vif.hs),          int'(e.hs));
                chk("vs",          int'(vif.vs),          int'(e.vs));
                chk("blank",       int'(vif.blank),       int'(e.blank));
                chk("line_start",  int'(vif.line_start),  int'(e.ls));
                chk("frame_start", int'(vif.frame_start), int'(e.fs));
                chk("sync",        int'(vif.sync),        0);
            end
        end
    end

    initial begin : stimulus
        int k;
        vif.en = 1'b0;
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 1300; i++) step(($urandom_range(0, 9) != 0), 1'b1);

        // Park with en low for 10 clocks at the start of a pixel (x=4), then resume.
        k = 0;
        while (k < 500 && !(((e_cnt / CLK_DIV) % HT) == 4 && (e_cnt % CLK_DIV) == 0)) begin
            step(1'b1, 1'b1);
            k++;
        end
        for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
        for (int i = 0; i < 20; i++) step(1'b1, 1'b1);

        // Asynchronous reset mid-line, away from pixel 0.
        k = 0;
        while (k < 1000 && !(((e_cnt / CLK_DIV) / HT) % VT == 3 && ((e_cnt / CLK_DIV) % HT) == 5)) begin
            step(1'b1, 1'b1);
            k++;
        end
        for (int i = 0; i < 2; i++) step(1'b1, 1'b0);
        for (int i = 0; i < 900; i++) step(($urandom_range(0, 4) != 0), 1'b1);

        // A few random short resets landing on arbitrary phases.
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < int'($urandom_range(5, 60)); i++) step(1'b1, 1'b1);
            step(($urandom_range(0, 1) != 0), 1'b0);
        end
        for (int i = 0; i < 100; i++) step(1'b1, 1'b1);

        @(negedge Clk);
        #1;
        chk("scoreboard_drained", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
